// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a divided clock
// and a one-cycle tick, with divisor reloads deferred to period boundaries.

// One divider channel: active/pending divisor, counter and registered outputs.
module clk_div_chan #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 20
) (
  input  logic             I_CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             sync,
  input  logic             load_hit,
  input  logic [CNT_W-1:0] load_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(32'd2);

  logic [CNT_W-1:0] div_r, pdiv_r, cnt_r;
  logic             clk_r, tick_r, pend_r;

  logic [CNT_W-1:0] div_s, pdiv_s, cnt_s;
  logic [CNT_W-1:0] half_s, div_last_s;
  logic             clk_s, tick_s, pend_s;
  logic             bypass_s, wrap_s;

  // Next-state for divisor bookkeeping, counter and the two outputs.
  always_comb begin
    div_s      = div_r;
    pdiv_s     = pdiv_r;
    pend_s     = pend_r;
    cnt_s      = cnt_r;
    clk_s      = clk_r;
    tick_s     = 1'b0;
    half_s     = div_r >> 1;
    div_last_s = div_r - ONE;
    bypass_s   = (div_r < TWO);
    wrap_s     = en & (bypass_s | (cnt_r == div_last_s));

    if (sync) begin
      // Phase restart; a pending divisor takes effect, any same-cycle write is dropped.
      if (pend_r) begin
        div_s  = pdiv_r;
        pend_s = 1'b0;
      end else begin
        div_s  = div_r;
      end
      cnt_s  = ZERO;
      clk_s  = 1'b0;
      tick_s = 1'b0;
    end else begin
      if (pend_r && (wrap_s || !en)) begin
        // New divisor starts a fresh period at cnt=0, which is always low.
        div_s  = pdiv_r;
        pend_s = 1'b0;
        cnt_s  = ZERO;
        clk_s  = 1'b0;
        tick_s = en & (pdiv_r < TWO);
      end else if (en) begin
        if (bypass_s) begin
          cnt_s  = ZERO;
          clk_s  = 1'b0;
          tick_s = 1'b1;
        end else begin
          cnt_s  = wrap_s ? ZERO : (cnt_r + ONE);
          clk_s  = (cnt_s >= half_s);
          tick_s = (cnt_s == half_s);
        end
      end else begin
        cnt_s = cnt_r;
        clk_s = clk_r;
      end

      // A write landing on a wrap edge queues behind the divisor just applied.
      if (load_hit) begin
        pdiv_s = load_div;
        pend_s = 1'b1;
      end else begin
        pdiv_s = pdiv_r;
      end
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (RST) begin
      div_r  <= DEF_DIV;
      pdiv_r <= ZERO;
      pend_r <= 1'b0;
      cnt_r  <= ZERO;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      div_r  <= div_s;
      pdiv_r <= pdiv_s;
      pend_r <= pend_s;
      cnt_r  <= cnt_s;
      clk_r  <= clk_s;
      tick_r <= tick_s;
    end
  end

  assign o_clk  = clk_r;
  assign o_tick = tick_r;
  assign pend   = pend_r;

endmodule

// Top level: CH independent channels sharing SYNC and the divisor write port.
module clk_div_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 20,
  parameter int SEL_W       = 2
) (
  input  logic             I_CLK,
  input  logic             RST,
  input  logic [CH-1:0]    EN,
  input  logic             SYNC,
  input  logic             LOAD,
  input  logic [SEL_W-1:0] LOAD_CH,
  input  logic [CNT_W-1:0] LOAD_DIV,
  output logic [CH-1:0]    O_CLK,
  output logic [CH-1:0]    O_TICK,
  output logic [CH-1:0]    PEND
);

  logic [CH-1:0] load_hit_s;

  // Out-of-range LOAD_CH values match no channel and are thus ignored.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign load_hit_s[i] = LOAD & (LOAD_CH == SEL_W'(i));

    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .I_CLK   (I_CLK),
      .RST     (RST),
      .en      (EN[i]),
      .sync    (SYNC),
      .load_hit(load_hit_s[i]),
      .load_div(LOAD_DIV),
      .o_clk   (O_CLK[i]),
      .o_tick  (O_TICK[i]),
      .pend    (PEND[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: the driver queues expected outputs per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_clk_div_multi;

  logic        I_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  EN = 4'b0000;
  logic        SYNC = 1'b0;
  logic        LOAD = 1'b0;
  logic [2:0]  LOAD_CH = 3'd0;
  logic [31:0] LOAD_DIV = 32'd0;
  logic [3:0]  O_CLK, O_TICK, PEND;

  clk_div_multi #(.CH(4), .CNT_W(32), .DEFAULT_DIV(20), .SEL_W(3)) dut (
    .I_CLK(I_CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .LOAD(LOAD),
    .LOAD_CH(LOAD_CH), .LOAD_DIV(LOAD_DIV),
    .O_CLK(O_CLK), .O_TICK(O_TICK), .PEND(PEND)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    string      name;
    logic [3:0] om;
    logic [3:0] pm;
    logic [3:0] clk;
    logic [3:0] tick;
    logic [3:0] pend;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [3:0] at(input int ch, input bit v);
    logic [3:0] r;
    r = 4'b0000;
    r[ch] = v;
    return r;
  endfunction

  function automatic bit dclk(input int cnt, input int div);
    return cnt >= div / 2;
  endfunction

  function automatic bit dtick(input int cnt, input int div);
    return cnt == div / 2;
  endfunction

  task automatic expect_edge(input string name, input logic [3:0] om, input logic [3:0] pm,
                             input logic [3:0] c, input logic [3:0] t, input logic [3:0] p);
    exp_t e;
    @(posedge I_CLK);
    #1;
    e.name = name; e.om = om; e.pm = pm; e.clk = c; e.tick = t; e.pend = p;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  always @(negedge I_CLK) begin
    while (sb_q.size() > 0) begin
      m = sb_q.pop_front();
      vectors++;
      if ((((O_CLK ^ m.clk) & m.om) !== 4'b0000) || (((O_TICK ^ m.tick) & m.om) !== 4'b0000) ||
          (((PEND ^ m.pend) & m.pm) !== 4'b0000)) begin
        miscompares++;
        $display("FAIL %s @%0t: got clk=%b tick=%b pend=%b, want clk=%b tick=%b pend=%b (omask=%b pmask=%b)",
                 m.name, $time, O_CLK, O_TICK, PEND, m.clk, m.tick, m.pend, m.om, m.pm);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c, t;
    // 1: reset, then channel 0 on the default divisor of 20
    run(1);
    expect_edge("reset", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    RST = 1'b0;
    EN  = 4'b0001;
    for (int k = 1; k <= 45; k++)
      expect_edge("t1_div20", 4'hF, 4'hF, at(0, dclk(k % 20, 20)), at(0, dtick(k % 20, 20)), 4'h0);

    // 2: ch1 DIV=4, then reload to 6 while cnt=1
    LOAD = 1'b1; LOAD_CH = 3'd1; LOAD_DIV = 32'd4;
    expect_edge("t2_pend", 4'b0010, 4'b0010, 4'h0, 4'h0, 4'b0010);
    LOAD = 1'b0;
    expect_edge("t2_apply_dis", 4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0);
    EN = 4'b0011;
    for (int k = 1; k <= 9; k++)
      expect_edge("t2_div4", 4'b0010, 4'b0010, at(1, dclk(k % 4, 4)), at(1, dtick(k % 4, 4)), 4'h0);
    LOAD = 1'b1; LOAD_CH = 3'd1; LOAD_DIV = 32'd6;
    expect_edge("t2_load_mid", 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    LOAD = 1'b0;
    expect_edge("t2_old_high", 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    expect_edge("t2_wrap_apply", 4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 12; k++)
      expect_edge("t2_div6", 4'b0010, 4'b0010, at(1, dclk(k % 6, 6)), at(1, dtick(k % 6, 6)), 4'h0);

    // 3: ch2 DIV=5, ch3 bypass with DIV=1 then DIV=0
    LOAD = 1'b1; LOAD_CH = 3'd2; LOAD_DIV = 32'd5;
    expect_edge("t3_pend2", 4'b0100, 4'b0100, 4'h0, 4'h0, 4'b0100);
    LOAD = 1'b0;
    expect_edge("t3_apply2", 4'b0100, 4'b0100, 4'h0, 4'h0, 4'h0);
    EN = 4'b0111;
    for (int k = 1; k <= 10; k++)
      expect_edge("t3_div5", 4'b0100, 4'b0100, at(2, dclk(k % 5, 5)), at(2, dtick(k % 5, 5)), 4'h0);
    LOAD = 1'b1; LOAD_CH = 3'd3; LOAD_DIV = 32'd1;
    expect_edge("t3_pend3", 4'b1000, 4'b1000, 4'h0, 4'h0, 4'b1000);
    LOAD = 1'b0;
    expect_edge("t3_apply3", 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0);
    EN = 4'b1111;
    for (int k = 1; k <= 4; k++)
      expect_edge("t3_div1", 4'b1000, 4'b1000, 4'h0, 4'b1000, 4'h0);
    LOAD = 1'b1; LOAD_CH = 3'd3; LOAD_DIV = 32'd0;
    expect_edge("t3_pend_div0", 4'b1000, 4'b1000, 4'h0, 4'b1000, 4'b1000);
    LOAD = 1'b0;
    for (int k = 1; k <= 4; k++)
      expect_edge("t3_div0", 4'b1000, 4'b1000, 4'h0, 4'b1000, 4'h0);
    EN = 4'b0111;
    expect_edge("t3_bypass_off", 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0);

    // 4: ch0 DIV=8 with a 7-cycle enable gap at cnt=5
    EN = 4'b0110;
    LOAD = 1'b1; LOAD_CH = 3'd0; LOAD_DIV = 32'd8;
    expect_edge("t4_pend0", 4'b0000, 4'b0001, 4'h0, 4'h0, 4'b0001);
    LOAD = 1'b0;
    expect_edge("t4_apply0", 4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0);
    EN = 4'b0111;
    for (int k = 1; k <= 5; k++)
      expect_edge("t4_div8", 4'b0001, 4'b0001, at(0, dclk(k, 8)), at(0, dtick(k, 8)), 4'h0);
    EN = 4'b0110;
    for (int k = 1; k <= 7; k++)
      expect_edge("t4_hold", 4'b0001, 4'b0001, 4'b0001, 4'h0, 4'h0);
    EN = 4'b0111;
    for (int k = 6; k <= 12; k++)
      expect_edge("t4_resume", 4'b0001, 4'b0001, at(0, dclk(k % 8, 8)), at(0, dtick(k % 8, 8)), 4'h0);

    // 5: DIV 4/6/10 on ch0/1/2, SYNC with a simultaneous (ignored) LOAD to ch3
    LOAD = 1'b1; LOAD_CH = 3'd0; LOAD_DIV = 32'd4;
    run(1);
    LOAD_CH = 3'd2; LOAD_DIV = 32'd10;
    run(1);
    SYNC = 1'b1; LOAD_CH = 3'd3; LOAD_DIV = 32'd7;
    expect_edge("t5_sync", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    SYNC = 1'b0; LOAD = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 13) begin
        LOAD = 1'b1; LOAD_CH = 3'd2; LOAD_DIV = 32'd3;
      end
      if (k == 14) LOAD = 1'b0;
      c = at(0, dclk(k % 4, 4)) | at(1, dclk(k % 6, 6)) | at(2, dclk(k % 10, 10));
      t = at(0, dtick(k % 4, 4)) | at(1, dtick(k % 6, 6)) | at(2, dtick(k % 10, 10));
      expect_edge("t5_phase", 4'hF, 4'hF, c, t, (k >= 13) ? 4'b0100 : 4'h0);
    end

    // 6: reset while ch0 is high and ch2 has a pending divisor, then an out-of-range LOAD
    RST = 1'b1;
    expect_edge("t6_reset", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    RST = 1'b0; EN = 4'b0001;
    LOAD = 1'b1; LOAD_CH = 3'd5; LOAD_DIV = 32'd2;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) LOAD = 1'b0;
      expect_edge("t6_div20", 4'hF, 4'hF, at(0, dclk(k, 20)), at(0, dtick(k, 20)), 4'h0);
    end

    @(negedge I_CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations never compared", sb_q.size());
    end else begin
      $display("scoreboard drained");
    end
    if (vectors < 100) begin
      miscompares++;
      $display("FAIL coverage: only %0d vectors compared", vectors);
    end else begin
      $display("vector count ok");
    end
    if (miscompares != 0) begin
      $display("FAIL: %0d miscompares", miscompares);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
